// File: rtl/snn_pkg.sv
// Shared types and helpers for the tinysnn neuron blocks.
package snn_pkg;

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRAC    = 1'b1
    } neuron_state_t;

    localparam logic RST_ZERO = 1'b0;
    localparam logic RST_SUB  = 1'b1;

    // Adds two signed values and clamps the result to the signed range of acc_w bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 acc_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/snn_syn_sum.sv
// Combinational masked signed sum of N_IN synaptic weights.
module snn_syn_sum #(
    parameter int N_IN  = 4,
    parameter int W_W   = 8,
    parameter int SUM_W = W_W + $clog2(N_IN) + 1
) (
    input  logic [N_IN-1:0]      i_spk,
    input  logic [N_IN*W_W-1:0]  i_weights,
    output logic signed [SUM_W-1:0] o_sum
);

    logic signed [SUM_W-1:0] w_term [N_IN];
    logic signed [SUM_W-1:0] w_acc;

    // Each weight is sign-extended to the full sum width so no partial sum can overflow.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_term
            assign w_term[gi] = i_spk[gi]
                ? {{(SUM_W-W_W){i_weights[gi*W_W+W_W-1]}}, i_weights[gi*W_W +: W_W]}
                : '0;
        end
    endgenerate

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_acc = w_acc + w_term[i];
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane, threshold, two reset modes,
// refractory window and a saturating spike counter.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int W_W        = 8,
    parameter int ACC_W      = 16,
    parameter int LEAK_SHIFT = 0,
    parameter int REFRAC_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [N_IN-1:0]         i_in_spk,
    input  logic [N_IN*W_W-1:0]     i_weights,
    input  logic [ACC_W-2:0]        i_threshold,
    input  logic                    i_reset_mode,
    output logic                    o_spike,
    output logic                    o_refrac_active,
    output logic signed [ACC_W-1:0] o_v_mem,
    output logic [CNT_W-1:0]        o_spike_cnt
);

    localparam int SUM_W = W_W + $clog2(N_IN) + 1;
    localparam int RC_W  = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;

    neuron_state_t           r_state, w_state_next;
    logic signed [ACC_W-1:0] r_v, w_v_next;
    logic                    r_spike, w_spike_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic [RC_W-1:0]         r_rc, w_rc_next;

    logic signed [SUM_W-1:0] w_syn_sum;
    logic signed [ACC_W-1:0] w_leak;
    logic signed [63:0]      w_sat;
    logic signed [ACC_W-1:0] w_v_int;
    logic signed [ACC_W-1:0] w_thr_ext;
    logic                    w_fire;

    snn_syn_sum #(
        .N_IN (N_IN),
        .W_W  (W_W),
        .SUM_W(SUM_W)
    ) u_syn_sum (
        .i_spk    (i_in_spk),
        .i_weights(i_weights),
        .o_sum    (w_syn_sum)
    );

    always_comb begin
        if (LEAK_SHIFT == 0) begin
            w_leak = '0;
        end else begin
            w_leak = r_v >>> LEAK_SHIFT;
        end
    end

    // Leak and synaptic input are combined at 64 bits and clamped once, so nothing wraps.
    assign w_sat     = sat_add(64'(r_v) - 64'(w_leak), 64'(w_syn_sum), ACC_W);
    assign w_v_int   = w_sat[ACC_W-1:0];
    assign w_thr_ext = {1'b0, i_threshold};
    assign w_fire    = (w_v_int >= w_thr_ext);

    always_comb begin
        w_state_next = r_state;
        w_v_next     = r_v;
        w_spike_next = 1'b0;
        w_cnt_next   = r_cnt;
        w_rc_next    = r_rc;
        if (i_en) begin
            case (r_state)
                INTEGRATE: begin
                    w_v_next = w_v_int;
                    if (w_fire) begin
                        w_spike_next = 1'b1;
                        if (i_reset_mode == RST_ZERO) begin
                            w_v_next = '0;
                        end else begin
                            w_v_next = w_v_int - w_thr_ext;
                        end
                        if (!(&r_cnt)) begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                        if (REFRAC_CYC > 0) begin
                            w_state_next = REFRAC;
                            w_rc_next    = RC_W'(REFRAC_CYC);
                        end
                    end
                end
                REFRAC: begin
                    // Membrane and inputs are frozen; only the window counter advances.
                    w_rc_next = r_rc - 1'b1;
                    if (r_rc <= RC_W'(1)) begin
                        w_state_next = INTEGRATE;
                    end
                end
                default: begin
                    w_state_next = INTEGRATE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= INTEGRATE;
            r_v     <= '0;
            r_spike <= 1'b0;
            r_cnt   <= '0;
            r_rc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_v     <= w_v_next;
            r_spike <= w_spike_next;
            r_cnt   <= w_cnt_next;
            r_rc    <= w_rc_next;
        end
    end

    assign o_spike         = r_spike;
    assign o_refrac_active = (r_state == REFRAC);
    assign o_v_mem         = r_v;
    assign o_spike_cnt     = r_cnt;

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Parametrised leaky integrate-and-fire neuron; the next generation of our single-input accumulate-and-fire neuron.
- Integrates N_IN weighted binary input spikes into a signed, saturating membrane potential, with:
  - optional exponential leak by arithmetic shift,
  - runtime threshold,
  - two reset modes (zero / subtract),
  - a refractory period,
  - a saturating output spike counter.
- Building block for the tinysnn layer arrays; one instance per output neuron.

Parameters:
- N_IN, 4, number of synaptic inputs (1..16)
- W_W, 8, width of each signed synaptic weight
- ACC_W, 16, membrane potential width, signed (must satisfy ACC_W >= W_W + clog2(N_IN) + 1)
- LEAK_SHIFT, 0, leak = v >>> LEAK_SHIFT; 0 disables leak
- REFRAC_CYC, 2, number of enabled cycles ignored after a spike; 0 means no refractory period
- CNT_W, 8, spike counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  timestep enable; all state holds when low
- in_spk  in  N_IN  input spike vector, bit i = synapse i
- weights  in  N_IN*W_W  flat signed weights; synapse i at [i*W_W +: W_W]
- threshold  in  ACC_W-1  unsigned firing threshold
- reset_mode  in  1  0 = reset v to 0 on fire; 1 = subtract threshold
- spike  out  1  registered one-cycle spike pulse
- refrac_active  out  1  high while in REFRAC state
- v_mem  out  ACC_W  current membrane potential (signed)
- spike_cnt  out  CNT_W  saturating count of spikes since reset

Behaviour:
- Reset, at the clock edge with rst=1:
  - v_mem=0, spike=0, refrac_active=0, spike_cnt=0
  - state=INTEGRATE, refractory counter=0
  - rst has priority over en.
- States: INTEGRATE, REFRAC. refrac_active = (state==REFRAC).
- Datapath:
  - syn_sum = signed sum of weights[i] over all i with in_spk[i]=1, computed at full width (no overflow internally).
  - leak = (LEAK_SHIFT==0) ? 0 : v_mem >>> LEAK_SHIFT (arithmetic shift).
  - v_next = sat(v_mem - leak + syn_sum), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Never wraps.
  - Fire condition: v_next >= threshold (threshold zero-extended, so always >= 0).
- en=0: all state holds, spike<=0.
- INTEGRATE with en=1, no fire:
  - v_mem<=v_next, spike<=0.
- INTEGRATE with en=1, fire:
  - spike<=1 (visible the cycle after the integrating edge; latency 1).
  - v_mem<= (reset_mode ? v_next - threshold : 0).
  - spike_cnt<=spike_cnt+1, saturating at all-ones.
  - If REFRAC_CYC>0: state<=REFRAC and counter<=REFRAC_CYC; otherwise stay in INTEGRATE.
- REFRAC with en=1:
  - in_spk ignored, no leak, v_mem held, spike<=0.
  - Counter decrements; when it is 1 at the edge, state<=INTEGRATE.
  - Result: exactly REFRAC_CYC enabled cycles are skipped.
- spike is never high on two consecutive cycles when REFRAC_CYC>0. With REFRAC_CYC=0, back-to-back spikes are legal.
- threshold and reset_mode are sampled every cycle. A change mid-integration applies at the next enabled edge.
- rst during REFRAC returns to INTEGRATE with all outputs cleared.
- Negative potentials are allowed. Leak on a negative v rounds toward -inf (arithmetic shift), e.g. -5>>>1 = -3 gives v = -2.

Decomposition:
- Shared package snn_pkg:
  - state enum (INTEGRATE, REFRAC)
  - saturating-add function
  - reset-mode constants RST_ZERO=0 and RST_SUB=1
- One sub-module, snn_syn_sum: combinational masked signed adder tree over N_IN weights. It is reusable by the layer arrays.
- The FSM, leak, saturation and counters live in lif_neuron.

Test Plan (defaults unless stated; weights all 10, threshold=100, reset_mode=0):
- Reset: rst high for 2 cycles with random inputs -> v_mem=0, spike=0, spike_cnt=0, refrac_active=0. Repeat with rst asserted while in REFRAC -> same result.
- Integrate/fire: in_spk=4'b0001 every cycle -> v_mem 10,20,...,90. On the 10th edge v_next=100, so spike=1 for one cycle, v_mem=0, spike_cnt=1.
- Refractory: continue the previous stimulus -> refrac_active=1 for 2 enabled cycles with v_mem=0. Integration resumes on the 3rd enabled edge (v_mem=10). Inserting en=0 cycles extends the window.
- Subtract mode: reset_mode=1, weights all 40, in_spk=4'b1111 -> first edge v_next=160, spike=1, v_mem=60.
- Leak: LEAK_SHIFT=2, drive v_mem to 64, then in_spk=0 -> v_mem 48,36,27,21. Negative: v=-5 gives -3, then -2.
- Saturation: weights all -128, in_spk=4'b1111 held -> v_mem decreases to -32768 and stays there, no wrap. CNT_W=2 with repeated firing -> spike_cnt holds at 3.
